// File: rtl/bus_arbiter.sv
// Round-robin two-master / three-slave arbiter and address-phase controller for the shared system bus.
// Latency: a request sampled on a clk edge appears on bus_grant right after that edge; there is a one-cycle turnaround gap between owners.
// Backpressure: the owner keeps the bus until slave_done, its request drops, or the watchdog expires; the other master waits.
//
// Ports:
//   clk, rstn                     bus clock (rising edge), asynchronous active-low reset
//   m1_req, m1_slave_sel          master 1 level request and target (0..2 = slave1..3, 3 = invalid)
//   m2_req, m2_slave_sel          master 2 level request and target
//   slave_done                    one-cycle end-of-transaction pulse from the selected slave
//   bus_grant                     01 = M1 owns the bus, 10 = M2 owns it, 00 = none
//   slave_grant                   one-hot slave select, 000 = none
//   bus_busy                      high while a grant is driven
//   timeout_err, decode_err       one-cycle error pulses
module bus_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       m1_req,
  input  logic [1:0] m1_slave_sel,
  input  logic       m2_req,
  input  logic [1:0] m2_slave_sel,
  input  logic       slave_done,
  output logic [1:0] bus_grant,
  output logic [2:0] slave_grant,
  output logic       bus_busy,
  output logic       timeout_err,
  output logic       decode_err
);

  typedef enum logic [1:0] {IDLE, GRANT_M1, GRANT_M2, RELEASE} state_t;

  // Counter value on the last cycle a grant may be held without completion.
  localparam logic [CNT_W-1:0] TMO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_m2_q, last_m2_d;   // 1 = M2 was the last owner
  logic [1:0]       bus_grant_d;
  logic [2:0]       slave_grant_d;
  logic             bus_busy_d, timeout_err_d, decode_err_d;
  logic             grant_m1, grant_m2, cur_req;

  function automatic logic [2:0] sel_onehot(input logic [1:0] sel);
    case (sel)
      2'd0:    sel_onehot = 3'b001;
      2'd1:    sel_onehot = 3'b010;
      2'd2:    sel_onehot = 3'b100;
      default: sel_onehot = 3'b000;
    endcase
  endfunction

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_m2_d     = last_m2_q;
    bus_grant_d   = bus_grant;
    slave_grant_d = slave_grant;
    bus_busy_d    = bus_busy;
    timeout_err_d = 1'b0;
    decode_err_d  = 1'b0;
    // On a tie the master that did not own the bus last wins.
    grant_m1      = m1_req && (!m2_req || last_m2_q);
    grant_m2      = m2_req && (!m1_req || !last_m2_q);
    cur_req       = (state_q == GRANT_M1) ? m1_req : m2_req;

    case (state_q)
      IDLE, RELEASE: begin
        if (grant_m1) begin
          state_d       = GRANT_M1;
          bus_grant_d   = 2'b01;
          slave_grant_d = sel_onehot(m1_slave_sel);
          bus_busy_d    = 1'b1;
          cnt_d         = '0;
          last_m2_d     = 1'b0;
          decode_err_d  = (m1_slave_sel == 2'd3);
        end else if (grant_m2) begin
          state_d       = GRANT_M2;
          bus_grant_d   = 2'b10;
          slave_grant_d = sel_onehot(m2_slave_sel);
          bus_busy_d    = 1'b1;
          cnt_d         = '0;
          last_m2_d     = 1'b1;
          decode_err_d  = (m2_slave_sel == 2'd3);
        end else begin
          state_d       = IDLE;
          bus_grant_d   = 2'b00;
          slave_grant_d = 3'b000;
          bus_busy_d    = 1'b0;
        end
      end
      GRANT_M1, GRANT_M2: begin
        // decode_err high means this grant cycle carried an invalid select: it lasts one cycle only.
        if (decode_err || slave_done || !cur_req ||
            ((TIMEOUT != 0) && (cnt_q == TMO_LAST))) begin
          state_d       = RELEASE;
          bus_grant_d   = 2'b00;
          slave_grant_d = 3'b000;
          bus_busy_d    = 1'b0;
          // Completion or abort take precedence over the watchdog.
          timeout_err_d = !decode_err && !slave_done && cur_req;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d       = IDLE;
        bus_grant_d   = 2'b00;
        slave_grant_d = 3'b000;
        bus_busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_m2_q   <= 1'b1;
      bus_grant   <= 2'b00;
      slave_grant <= 3'b000;
      bus_busy    <= 1'b0;
      timeout_err <= 1'b0;
      decode_err  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_m2_q   <= last_m2_d;
      bus_grant   <= bus_grant_d;
      slave_grant <= slave_grant_d;
      bus_busy    <= bus_busy_d;
      timeout_err <= timeout_err_d;
      decode_err  <= decode_err_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with TIMEOUT=8.
// Outputs are packed as {bus_grant, slave_grant, bus_busy, timeout_err, decode_err}.
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       rstn;
  logic       m1_req, m2_req, slave_done;
  logic [1:0] m1_slave_sel, m2_slave_sel;
  logic [1:0] bus_grant;
  logic [2:0] slave_grant;
  logic       bus_busy, timeout_err, decode_err;
  logic [7:0] outs;

  int total = 0;
  int bad   = 0;

  bus_arbiter #(.TIMEOUT(8), .CNT_W(8)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .m1_req       (m1_req),
    .m1_slave_sel (m1_slave_sel),
    .m2_req       (m2_req),
    .m2_slave_sel (m2_slave_sel),
    .slave_done   (slave_done),
    .bus_grant    (bus_grant),
    .slave_grant  (slave_grant),
    .bus_busy     (bus_busy),
    .timeout_err  (timeout_err),
    .decode_err   (decode_err)
  );

  always #5 clk = ~clk;

  assign outs = {bus_grant, slave_grant, bus_busy, timeout_err, decode_err};

  localparam logic [7:0] IDLE_O = 8'b00_000_0_0_0;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; m1_req = 0; m2_req = 0; slave_done = 0;
    m1_slave_sel = 2'd0; m2_slave_sel = 2'd0;
    #1;
    check_val("reset_async", outs, IDLE_O);
    step(); step();
    check_val("reset_held", outs, IDLE_O);
    rstn = 1'b1;
    step();
    check_val("idle_after_reset", outs, IDLE_O);

    // Single M1 transaction to slave2, completed by slave_done.
    m1_req = 1; m1_slave_sel = 2'd1;
    step(); check_val("t1_grant", outs, 8'b01_010_1_0_0);
    step(); check_val("t1_hold", outs, 8'b01_010_1_0_0);
    slave_done = 1;
    step(); check_val("t1_release", outs, IDLE_O);
    slave_done = 0; m1_req = 0;
    step(); check_val("t1_idle", outs, IDLE_O);
    slave_done = 1;
    step(); check_val("done_in_idle", outs, IDLE_O);
    slave_done = 0;

    // Both masters request together after reset: M1 first, then alternate.
    do_reset();
    m1_req = 1; m2_req = 1; m1_slave_sel = 2'd0; m2_slave_sel = 2'd0;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++) begin
        step();
        check_val($sformatf("rr_r%0d_c%0d", r, k), outs,
                  (r % 2 == 0) ? 8'b01_001_1_0_0 : 8'b10_001_1_0_0);
      end
      slave_done = 1;
      step(); check_val($sformatf("rr_r%0d_rel", r), outs, IDLE_O);
      slave_done = 0;
    end
    m1_req = 0; m2_req = 0;
    step(); check_val("rr_idle", outs, IDLE_O);

    // Watchdog: M2 to slave3 with no completion for 8 cycles.
    m2_req = 1; m2_slave_sel = 2'd2;
    for (int k = 0; k < 8; k++) begin
      step(); check_val($sformatf("tmo_c%0d", k), outs, 8'b10_100_1_0_0);
    end
    step(); check_val("tmo_release", outs, 8'b00_000_0_1_0);
    step(); check_val("tmo_regrant", outs, 8'b10_100_1_0_0);
    m2_req = 0;
    step(); check_val("tmo_abort", outs, IDLE_O);
    step(); check_val("tmo_idle", outs, IDLE_O);

    // Invalid slave select.
    m1_req = 1; m1_slave_sel = 2'd3;
    step(); check_val("dec_grant", outs, 8'b01_000_1_0_1);
    m1_req = 0;
    step(); check_val("dec_release", outs, IDLE_O);
    step(); check_val("dec_idle", outs, IDLE_O);

    // Select change mid-grant is ignored; abort by dropping request.
    m1_req = 1; m1_slave_sel = 2'd0;
    step(); check_val("sel_grant", outs, 8'b01_001_1_0_0);
    m1_slave_sel = 2'd2;
    step(); check_val("sel_hold1", outs, 8'b01_001_1_0_0);
    step(); check_val("sel_hold2", outs, 8'b01_001_1_0_0);
    m1_req = 0;
    step(); check_val("sel_abort", outs, IDLE_O);
    step(); check_val("sel_idle", outs, IDLE_O);

    // slave_done and request drop on the same edge.
    m1_req = 1; m1_slave_sel = 2'd1;
    step(); check_val("both_grant", outs, 8'b01_010_1_0_0);
    slave_done = 1; m1_req = 0;
    step(); check_val("both_release", outs, IDLE_O);
    slave_done = 0;
    step(); check_val("both_idle", outs, IDLE_O);

    // slave_done on the watchdog cycle is a normal completion.
    m2_req = 1; m2_slave_sel = 2'd1;
    for (int k = 0; k < 8; k++) begin
      step(); check_val($sformatf("dtmo_c%0d", k), outs, 8'b10_010_1_0_0);
    end
    slave_done = 1;
    step(); check_val("dtmo_release", outs, IDLE_O);
    slave_done = 0; m2_req = 0;
    step(); check_val("dtmo_idle", outs, IDLE_O);

    // Reset in the middle of an M2 grant.
    m2_req = 1; m2_slave_sel = 2'd2;
    step(); check_val("mr_grant", outs, 8'b10_100_1_0_0);
    #2 rstn = 1'b0;
    #1 check_val("mr_async_clear", outs, IDLE_O);
    m1_req = 1; m1_slave_sel = 2'd0; m2_slave_sel = 2'd0;
    step(); check_val("mr_held", outs, IDLE_O);
    rstn = 1'b1;
    step(); check_val("mr_tie_m1", outs, 8'b01_001_1_0_0);
    m1_req = 0; m2_req = 0;
    step(); check_val("mr_release", outs, IDLE_O);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
